// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned bcd_max(input int unsigned digits);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    always_comb begin
        adj_c = (digit >= 4'd5) ? 4'(digit + 4'd3) : digit;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle shift/add-3 binary-to-BCD converter with start/done handshake.
// Optional BIN2BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits on the output.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  enable_display,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned     BCD_W   = 4 * DIGITS;
    localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = bcd_max(DIGITS);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   disp;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (scratch_q[4*g +: 4]),
            .adj_c (scratch_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                // Carries out of the top digit are dropped; overflow saturation covers them.
                scratch_d = BCD_W'({scratch_adj, shreg_q[BIN_W-1]});
                shreg_d   = shreg_q << 1;
                cnt_d     = CNT_W'(cnt_q - CNT_W'(1));
                busy_d    = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    result_d   = ovf_pend_q ? ALL_NINES : BCD_W'({scratch_adj, shreg_q[BIN_W-1]});
                    overflow_d = ovf_pend_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture is shared by IDLE and DONE so back-to-back conversions need no gap.
        if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
            state_d    = ST_SHIFT;
            shreg_d    = bin_in;
            scratch_d  = '0;
            cnt_d      = CNT_W'(BIN_W);
            ovf_pend_d = (64'(bin_in) > MAX_VAL);
            busy_d     = 1'b1;
        end
    end

    always_comb begin
        disp = result_q;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
                if (result_q[4*k +: 4] != 4'h0) begin
                    lead = 1'b0;
                end
                if (lead) begin
                    disp[4*k +: 4] = BLANK_DIGIT;
                end
            end
        end
`endif
        bcd_out = enable_display ? disp : {DIGITS{BLANK_DIGIT}};
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (BIN_W=14, DIGITS=4): vector table, corner sequences, random values.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        enable_display;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] bcd_out;

    int n_cmp = 0;
    int n_err = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .bin_in         (bin_in),
        .enable_display (enable_display),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .bcd_out        (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] val;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by arithmetic, saturating above 9999.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          p;
        if (v > 9999) return 16'h9999;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Display view of a stored result.
    function automatic logic [15:0] ref_disp(input logic [15:0] stored, input logic en);
        logic [15:0] d;
        d = stored;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        for (int k = 3; k >= 1; k--) begin
            if (stored[4*k +: 4] != 4'h0) break;
            d[4*k +: 4] = 4'hF;
        end
`endif
        return en ? d : 16'hFFFF;
    endfunction

    // Starts a conversion from a negedge; returns latency (in cycles) to done and busy count.
    task automatic run(input logic [13:0] v, input bit poke, output int lat, output int bcnt);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'($urandom);
        lat    = 1;
        bcnt   = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            start = poke && (lat == 3 || lat == 7);
            if (start) bin_in = 14'($urandom_range(0, 16383));
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int v, input int lat, input int bcnt);
        chk({tag, "_lat"}, 32'(lat), 32'd15);
        chk({tag, "_busy"}, 32'(bcnt), 32'd14);
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(ref_disp(ref_bcd(v), 1'b1)));
        chk({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
    endtask

    initial begin
        vec_t tbl[8];
        int   lat, bcnt, seen;
        logic [13:0] v;

        tbl[0] = '{14'd59,    16'h0059, 1'b0};
        tbl[1] = '{14'd2024,  16'h2024, 1'b0};
        tbl[2] = '{14'd9999,  16'h9999, 1'b0};
        tbl[3] = '{14'd10000, 16'h9999, 1'b1};
        tbl[4] = '{14'd0,     16'h0000, 1'b0};
        tbl[5] = '{14'd1,     16'h0001, 1'b0};
        tbl[6] = '{14'd16383, 16'h9999, 1'b1};
        tbl[7] = '{14'd305,   16'h0305, 1'b0};

        rst_n = 1'b0; start = 1'b0; bin_in = '0; enable_display = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'(ref_disp(16'h0000, 1'b1)));
        enable_display = 1'b0;
        #1 chk("rst_blank", 32'(bcd_out), 32'h0000FFFF);
        enable_display = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].val, 1'b0, lat, bcnt);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd15);
            chk($sformatf("tbl%0d_busy", i), 32'(bcnt), 32'd14);
            chk($sformatf("tbl%0d_bcd", i), 32'(bcd_out), 32'(ref_disp(tbl[i].exp_bcd, 1'b1)));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
            @(negedge clk);
            chk($sformatf("tbl%0d_pulse", i), 32'(done), 32'd0);
            chk($sformatf("tbl%0d_hold", i), 32'(bcd_out), 32'(ref_disp(tbl[i].exp_bcd, 1'b1)));
        end

        // Back-to-back: start asserted in the DONE cycle.
        run(14'd2024, 1'b0, lat, bcnt);
        check_result("b2b_a", 2024, lat, bcnt);
        run(14'd9999, 1'b0, lat, bcnt);
        check_result("b2b_b", 9999, lat, bcnt);

        // Start re-pulsed mid-conversion is ignored.
        @(negedge clk);
        run(14'd1234, 1'b1, lat, bcnt);
        check_result("ignore", 1234, lat, bcnt);

        // Result holds while the next conversion runs.
        run(14'd10000, 1'b0, lat, bcnt);
        check_result("ovf", 10000, lat, bcnt);
        start = 1'b1; bin_in = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midhold_busy", 32'(busy), 32'd1);
        chk("midhold_bcd", 32'(bcd_out), 32'h00009999);
        chk("midhold_ovf", 32'(overflow), 32'd1);

        // Reset at SHIFT cycle 5 aborts the conversion.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        chk("abort_bcd", 32'(bcd_out), 32'(ref_disp(16'h0000, 1'b1)));
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        enable_display = 1'b0;
        #1 chk("abort_blank", 32'(bcd_out), 32'h0000FFFF);
        enable_display = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            v = 14'($urandom_range(0, 16383));
            run(v, 1'b0, lat, bcnt);
            check_result($sformatf("rnd%0d", i), int'(v), lat, bcnt);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Multi-cycle, parametrised binary-to-BCD converter using the shift/add-3 (double dabble) algorithm, one input bit processed per clock.
- Replaces the fixed 6/7-bit combinational converters in the clock/calendar display path; a single instance handles full 4-digit years.
- Has a start/done handshake, result hold, overflow saturation and per-output display blanking.

Parameters:
- BIN_W, 14, binary input width in bits; legal range 1..32.
- DIGITS, 4, number of BCD output digits; legal range 1..10.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE or DONE.
- bin_in  input  BIN_W  unsigned binary value; captured in the cycle start is accepted.
- enable_display  input  1  0 forces every output digit to 4'hF (blank); combinational on the registered result.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a new result is committed.
- overflow  output  1  registered; set when the last captured value exceeded 10^DIGITS-1.
- bcd_out  output  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k], with digit 0 as the units digit.

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, go to IDLE and clear busy, done, overflow, the result register and the bit counter.
- After reset, bcd_out reads all zeros when enable_display=1 and all 4'hF when enable_display=0.
- FSM states:
  - IDLE: start=1 captures bin_in into a shift register, clears the scratch BCD register, loads the counter with BIN_W and goes to SHIFT.
  - SHIFT: each cycle, every 4-bit scratch digit that is >=5 gets +3. Then {scratch, shift} is shifted left by one, bringing in the shift-register MSB. The counter decrements; when it reaches 1, go to DONE.
  - DONE: done=1 for this single cycle.
    - start=1 in this cycle begins a new capture and goes directly to SHIFT (back-to-back conversions).
    - Otherwise go to IDLE.
- Cycle timing: busy=1 in every SHIFT cycle and 0 in IDLE and DONE. If start is accepted at edge t0, done is high in cycle t0+BIN_W+1, so the latency is BIN_W+1 cycles.
- Result register:
  - Updated only on the SHIFT->DONE transition.
  - Otherwise holds its value indefinitely, including while the next conversion runs.
- Overflow:
  - Computed at capture as bin_in > 10^DIGITS-1, using a compile-time constant.
  - When set, the committed result is all digits 4'h9.
  - The flag itself updates together with the result.
- start while busy=1 is ignored; there is no queueing.
- bin_in changes after capture have no effect.
- Reset asserted mid-conversion aborts the conversion: the FSM returns to IDLE, done is not pulsed, and the result is cleared.
- The scratch register is 4*DIGITS bits wide and the counter is $clog2(BIN_W+1) bits wide. Bits carried out of the top digit are discarded; the overflow path guarantees the output is still valid.
- bin_in=0 produces all-zero digits after the full latency; there is no early exit.

Optional Feature:
- Macro: BIN2BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Every zero digit more significant than the most significant non-zero digit is output as 4'hF.
  - Digit 0 is never blanked, so a value of 0 displays as a single "0".
  - This is applied combinationally after the result register and before the enable_display mux.
  - Overflow (all 9s) is unaffected.
- Undefined: digits are output exactly as stored, leading zeros included.

Decomposition:
- Package bcd_pkg:
  - BLANK_DIGIT = 4'hF.
  - FSM state encoding (IDLE, SHIFT, DONE).
  - Function bcd_max(DIGITS) returning 10^DIGITS-1.
- Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times through a generate loop inside the SHIFT datapath.

Test Plan:
- BIN_W=14, DIGITS=4, bin_in=59, start pulse: busy high 14 cycles, done at cycle 15, bcd_out=16'h0059, overflow=0.
- bin_in=2024, then bin_in=9999 with start asserted in the DONE cycle: results 16'h2024 then 16'h9999; the second done arrives exactly 15 cycles after the first.
- bin_in=10000: overflow=1, bcd_out=16'h9999. A following bin_in=0 gives overflow=0 and bcd_out=16'h0000.
- start re-pulsed at cycles 3 and 7 of a conversion with different bin_in values: ignored, and the original value's result is committed.
- rst_n=0 at SHIFT cycle 5: next cycle busy=0, done never pulses, bcd_out=0. Toggling enable_display=0 then gives 16'hFFFF.
- With BIN2BCD_LEADING_ZERO_BLANK_EN defined: bin_in=7 gives 16'hFFF7, bin_in=0 gives 16'hFFF0, bin_in=305 gives 16'hF305.
